// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction fetch queue
package fetch_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO of fetched words with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential fetch front end with redirect flush; optional FETCH_MISALIGN_CHECK_EN
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        InstrMisalign
`endif
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   dropcnt_q, dropcnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] redirect_pc;
  logic            fifo_empty, fifo_full, fetch_block;
  logic            issue, resp_live, push, pop;
  fetch_entry_t    push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_pc   = RedirectPC;
  assign fetch_block   = misalign_q;
  assign InstrMisalign = misalign_q;

  always_comb begin
    misalign_d = misalign_q;
    if (Redirect) misalign_d = (RedirectPC[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end
`else
  logic [1:0] redirect_lsb_unused;

  assign redirect_lsb_unused = RedirectPC[1:0];
  assign redirect_pc         = {RedirectPC[31:2], 2'b00};
  assign fetch_block         = 1'b0;
`endif

  // Every in-flight fetch owns a FIFO slot, so a response can never find it full.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign IMemReq   = reset_n & ~Redirect & ~fetch_block & ~fifo_full & (occupancy < DEPTH_OCC);
  assign IMemAddr  = fetch_pc_q;
  assign issue     = IMemReq & IMemGnt;

  // Responses with nothing outstanding (e.g. straight after reset) are ignored.
  assign resp_live  = IMemRValid & (inflight_q != '0);
  assign push       = resp_live & ~Redirect & (dropcnt_q == '0);
  assign push_entry = '{instr: IMemRData, pc: tag_q};

  assign InstrValid = ~fifo_empty & ~fetch_block;
  assign pop        = InstrValid & InstrReady & ~Redirect;
  assign Instr      = InstrValid ? head_entry.instr : NOP_INSTR;
  assign InstrPC    = InstrValid ? head_entry.pc : '0;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (Redirect),
    .head_o     (head_entry),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    dropcnt_d  = dropcnt_q;
    if (issue)     inflight_d = inflight_d + CNT_ONE;
    if (resp_live) inflight_d = inflight_d - CNT_ONE;
    if (Redirect) begin
      fetch_pc_d = redirect_pc;
      tag_d      = redirect_pc;
      // Everything still outstanding after this cycle belongs to the old path.
      dropcnt_d  = resp_live ? (inflight_q - CNT_ONE) : inflight_q;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_INCR;
      if (push)  tag_d = tag_q + PC_INCR;
      if (resp_live && (dropcnt_q != '0)) dropcnt_d = dropcnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= '0;
      dropcnt_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      dropcnt_q  <= dropcnt_d;
    end
  end

endmodule
